// File: rtl/span_layer_renderer_if.sv
// Pixel, timing, table-write and colour signals shared between the VGA
// timing/sequencer side and the span layer renderer.
interface span_if #(
  parameter int NUM_LAYERS    = 2,
  parameter int NUM_BANDS     = 16,
  parameter int SPANS_PER_ROW = 4,
  parameter int COORD_W       = 10,
  parameter int FRAME_W       = 10,
  parameter int COLOUR_W      = 6
);
  localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int ADDR_W  = $clog2(NUM_BANDS * SPANS_PER_ROW);

  logic [COORD_W-1:0]   x_pos;
  logic [COORD_W-1:0]   y_pos;
  logic                 frame_start;
  logic                 line_start;
  logic [FRAME_W-1:0]   frame;
  logic [COLOUR_W-1:0]  bg_colour;
  logic                 wr_en;
  logic [LAYER_W-1:0]   wr_layer;
  logic [1:0]           wr_sel;
  logic [ADDR_W-1:0]    wr_addr;
  logic [COORD_W+7:0]   wr_data;
  logic [COLOUR_W-1:0]  colour;
  logic [NUM_LAYERS-1:0] layer_hit;

  modport master (
    output x_pos, y_pos, frame_start, line_start, frame, bg_colour,
           wr_en, wr_layer, wr_sel, wr_addr, wr_data,
    input  colour, layer_hit
  );

  modport slave (
    input  x_pos, y_pos, frame_start, line_start, frame, bg_colour,
           wr_en, wr_layer, wr_sel, wr_addr, wr_data,
    output colour, layer_hit
  );
endinterface

// File: rtl/span_layer_renderer.sv
// Multi-layer scanline span renderer: each layer walks writable Y-band and
// X-span edge tables with frame-linear motion; fixed-priority composite.
module span_layer_renderer #(
  parameter int NUM_LAYERS    = 2,
  parameter int NUM_BANDS     = 16,
  parameter int SPANS_PER_ROW = 4,
  parameter int COORD_W       = 10,
  parameter int FRAME_W       = 10,
  parameter int COLOUR_W      = 6
) (
  input  logic clk,
  input  logic rst,
  span_if.slave bus
);
  localparam int BAND_W = $clog2(NUM_BANDS);
  localparam int SPAN_W = $clog2(SPANS_PER_ROW);
  localparam int NX     = NUM_BANDS * SPANS_PER_ROW;
  localparam int EW     = COORD_W + 1;
  localparam int PW     = FRAME_W + 9;

  logic [COORD_W-1:0]  y_base [NUM_LAYERS][NUM_BANDS];
  logic [7:0]          y_off  [NUM_LAYERS][NUM_BANDS];
  logic [COORD_W-1:0]  x_base [NUM_LAYERS][NX];
  logic [7:0]          x_off  [NUM_LAYERS][NX];
  logic [NUM_LAYERS-1:0] enable;
  logic [BAND_W-1:0]   band_base [NUM_LAYERS];
  logic [COLOUR_W-1:0] in_colour [NUM_LAYERS];

  logic [BAND_W-1:0]   y_idx [NUM_LAYERS];
  logic [SPAN_W:0]     x_idx [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] in_span;
  logic [NUM_LAYERS-1:0] y_match;
  logic [NUM_LAYERS-1:0] x_match;
  logic [NUM_LAYERS-1:0] hit;
  logic [COLOUR_W-1:0] next_colour;

  // Offset is signed 3.5 fixed point; the all-ones base is a never-match sentinel.
  function automatic logic edge_match(input logic [COORD_W-1:0] base,
                                      input logic [7:0]         off,
                                      input logic [FRAME_W-1:0] fr,
                                      input logic [COORD_W-1:0] pos);
    logic signed [PW-1:0] prod;
    logic [EW-1:0]        e;
    prod = $signed(off) * $signed({1'b0, fr});
    e    = {1'b0, base} + EW'(prod >>> 5);
    return (base != '1) && (e == {1'b0, pos});
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          y_base[l][b] <= '1;
          y_off[l][b]  <= '0;
        end
        for (int e = 0; e < NX; e++) begin
          x_base[l][e] <= '1;
          x_off[l][e]  <= '0;
        end
        band_base[l] <= '0;
        in_colour[l] <= '0;
      end
      enable <= '0;
    end else if (bus.wr_en && (int'(bus.wr_layer) < NUM_LAYERS)) begin
      case (bus.wr_sel)
        2'd0: begin
          if (int'(bus.wr_addr) < NUM_BANDS) begin
            y_base[bus.wr_layer][bus.wr_addr[BAND_W-1:0]] <= bus.wr_data[COORD_W-1:0];
            y_off[bus.wr_layer][bus.wr_addr[BAND_W-1:0]]  <= bus.wr_data[COORD_W+7:COORD_W];
          end
        end
        2'd1: begin
          x_base[bus.wr_layer][bus.wr_addr] <= bus.wr_data[COORD_W-1:0];
          x_off[bus.wr_layer][bus.wr_addr]  <= bus.wr_data[COORD_W+7:COORD_W];
        end
        2'd2: begin
          if (int'(bus.wr_addr) == 0) begin
            enable[bus.wr_layer]    <= bus.wr_data[0];
            band_base[bus.wr_layer] <= bus.wr_data[BAND_W:1];
          end else if (int'(bus.wr_addr) == 1) begin
            in_colour[bus.wr_layer] <= bus.wr_data[COLOUR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    y_match = '0;
    x_match = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      y_match[l] = edge_match(y_base[l][y_idx[l]], y_off[l][y_idx[l]],
                              bus.frame, bus.y_pos);
      // x_idx == SPANS_PER_ROW means the row's edges are exhausted
      x_match[l] = !x_idx[l][SPAN_W] &&
                   edge_match(x_base[l][{y_idx[l], x_idx[l][SPAN_W-1:0]}],
                              x_off[l][{y_idx[l], x_idx[l][SPAN_W-1:0]}],
                              bus.frame, bus.x_pos);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        y_idx[l] <= '0;
        x_idx[l] <= '0;
      end
      in_span <= '0;
    end else begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if (bus.frame_start) begin
          y_idx[l]   <= band_base[l];
          x_idx[l]   <= '0;
          in_span[l] <= 1'b0;
        end else if (bus.line_start) begin
          if (y_match[l] && (y_idx[l] != '1))
            y_idx[l] <= y_idx[l] + 1'b1;
          x_idx[l]   <= '0;
          in_span[l] <= 1'b0;
        end else if (x_match[l]) begin
          x_idx[l]   <= x_idx[l] + 1'b1;
          in_span[l] <= ~in_span[l];
        end
      end
    end
  end

  always_comb begin
    hit         = enable & in_span;
    next_colour = bus.bg_colour;
    for (int l = NUM_LAYERS - 1; l >= 0; l--)
      if (hit[l]) next_colour = in_colour[l];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.colour    <= '0;
      bus.layer_hit <= '0;
    end else begin
      bus.colour    <= next_colour;
      bus.layer_hit <= hit;
    end
  end
endmodule
